// File: rtl/equal_precision_freq_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : equal_precision_freq_meter                                        |
// | Brief  : Equal-precision frequency meter; gate opens/closes on clk_fx edges |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module equal_precision_freq_meter #(
    parameter int GATE_CYCLES    = 50_000_000,
    parameter int TIMEOUT_CYCLES = 100_000_000,
    parameter int CNT_W          = 32,
    parameter int AUTO_RESTART   = 0
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             clk_fx,
    input  logic             start,
    output logic             busy,
    output logic             meas_valid,
    output logic [CNT_W-1:0] fx_cnt,
    output logic [CNT_W-1:0] fs_cnt,
    output logic             err_timeout,
    output logic             err_ovf
);

    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [GATE_W-1:0] c_gate_last = GATE_W'(GATE_CYCLES - 1);
    localparam logic [TMO_W-1:0]  c_tmo_last  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_cnt_one   = CNT_W'(1);
    localparam logic [GATE_W-1:0] c_gate_one  = GATE_W'(1);
    localparam logic [TMO_W-1:0]  c_tmo_one   = TMO_W'(1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_OPEN  = 3'd1,
        S_GATE       = 3'd2,
        S_WAIT_CLOSE = 3'd3,
        S_DONE       = 3'd4
    } state_t;

    state_t             r_state, w_state_nxt;
    logic               r_s1, r_s2, r_s3;
    logic [CNT_W-1:0]   r_fs, r_fx, w_fs_nxt, w_fx_nxt;
    logic [GATE_W-1:0]  r_gate, w_gate_nxt;
    logic [TMO_W-1:0]   r_wait, w_wait_nxt;
    logic               w_fx_rise, w_fs_full;
    logic               w_publish, w_tmo, w_ovf;
    logic               r_meas_valid, r_err_timeout, r_err_ovf;
    logic [CNT_W-1:0]   r_fx_cnt, r_fs_cnt;

    assign w_fx_rise = r_s2 & ~r_s3;
    assign w_fs_full = &r_fs;

    always_comb begin
        w_state_nxt = r_state;
        w_fs_nxt    = r_fs;
        w_fx_nxt    = r_fx;
        w_gate_nxt  = r_gate;
        w_wait_nxt  = r_wait;
        w_publish   = 1'b0;
        w_tmo       = 1'b0;
        w_ovf       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_WAIT_OPEN;
                    w_wait_nxt  = '0;
                end
            end
            S_WAIT_OPEN: begin
                if (w_fx_rise) begin
                    w_state_nxt = S_GATE;
                    w_fs_nxt    = '0;
                    w_fx_nxt    = '0;
                    w_gate_nxt  = '0;
                end else if (r_wait == c_tmo_last) begin
                    w_state_nxt = S_IDLE;
                    w_tmo       = 1'b1;
                end else begin
                    w_wait_nxt  = r_wait + c_tmo_one;
                end
            end
            S_GATE: begin
                if (w_fs_full) begin
                    w_state_nxt = S_IDLE;
                    w_ovf       = 1'b1;
                end else begin
                    w_fs_nxt   = r_fs + c_cnt_one;
                    w_gate_nxt = r_gate + c_gate_one;
                    if (w_fx_rise) w_fx_nxt = r_fx + c_cnt_one;
                    // A rise on the final gate cycle is counted but cannot close the gate.
                    if (r_gate == c_gate_last) begin
                        w_state_nxt = S_WAIT_CLOSE;
                        w_wait_nxt  = '0;
                    end
                end
            end
            S_WAIT_CLOSE: begin
                if (w_fs_full) begin
                    w_state_nxt = S_IDLE;
                    w_ovf       = 1'b1;
                end else begin
                    w_fs_nxt = r_fs + c_cnt_one;
                    if (w_fx_rise) begin
                        w_fx_nxt    = r_fx + c_cnt_one;
                        w_state_nxt = S_DONE;
                        w_publish   = 1'b1;
                    end else if (r_wait == c_tmo_last) begin
                        w_state_nxt = S_IDLE;
                        w_tmo       = 1'b1;
                    end else begin
                        w_wait_nxt  = r_wait + c_tmo_one;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = (AUTO_RESTART != 0) ? S_WAIT_OPEN : S_IDLE;
                w_wait_nxt  = '0;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_s1          <= 1'b0;
            r_s2          <= 1'b0;
            r_s3          <= 1'b0;
            r_fs          <= '0;
            r_fx          <= '0;
            r_gate        <= '0;
            r_wait        <= '0;
            r_meas_valid  <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_ovf     <= 1'b0;
            r_fx_cnt      <= '0;
            r_fs_cnt      <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_s1          <= clk_fx;
            r_s2          <= r_s1;
            r_s3          <= r_s2;
            r_fs          <= w_fs_nxt;
            r_fx          <= w_fx_nxt;
            r_gate        <= w_gate_nxt;
            r_wait        <= w_wait_nxt;
            r_meas_valid  <= w_publish;
            r_err_timeout <= w_tmo;
            r_err_ovf     <= w_ovf;
            // Results move only on a clean close, so aborts leave the last result visible.
            if (w_publish) begin
                r_fx_cnt <= w_fx_nxt;
                r_fs_cnt <= w_fs_nxt;
            end
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign meas_valid  = r_meas_valid;
    assign err_timeout = r_err_timeout;
    assign err_ovf     = r_err_ovf;
    assign fx_cnt      = r_fx_cnt;
    assign fs_cnt      = r_fs_cnt;

endmodule
`default_nettype wire

// File: tb/tb_equal_precision_freq_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_equal_precision_freq_meter                                     |
// | Brief  : Directed bench for equal_precision_freq_meter (five configurations)|
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_equal_precision_freq_meter;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        a_rst_ok = 1'b1;
    logic        clk_fx  = 1'b0;
    logic        fx_en_t = 1'b1;
    logic [4:0]  start_v = '0;
    logic        rst_a, fx_t;

    assign rst_a = rst_n & a_rst_ok;
    assign fx_t  = clk_fx & fx_en_t;

    logic        busy_a, mv_a, to_a, ovf_a;  logic [31:0] fx_a, fs_a;
    logic        busy_b, mv_b, to_b, ovf_b;  logic [31:0] fx_b, fs_b;
    logic        busy_t, mv_t, to_t, ovf_t;  logic [31:0] fx_tc, fs_tc;
    logic        busy_r, mv_r, to_r, ovf_r;  logic [31:0] fx_r, fs_r;
    logic        busy_o, mv_o, to_o, ovf_o;  logic [11:0] fx_o, fs_o;

    equal_precision_freq_meter #(.GATE_CYCLES(9500), .TIMEOUT_CYCLES(20000)) u_a (
        .sys_clk(sys_clk), .rst_n(rst_a), .clk_fx(clk_fx), .start(start_v[0]),
        .busy(busy_a), .meas_valid(mv_a), .fx_cnt(fx_a), .fs_cnt(fs_a),
        .err_timeout(to_a), .err_ovf(ovf_a));
    equal_precision_freq_meter #(.GATE_CYCLES(10000), .TIMEOUT_CYCLES(20000)) u_b (
        .sys_clk(sys_clk), .rst_n(rst_n), .clk_fx(clk_fx), .start(start_v[1]),
        .busy(busy_b), .meas_valid(mv_b), .fx_cnt(fx_b), .fs_cnt(fs_b),
        .err_timeout(to_b), .err_ovf(ovf_b));
    equal_precision_freq_meter #(.GATE_CYCLES(9500), .TIMEOUT_CYCLES(5000)) u_t (
        .sys_clk(sys_clk), .rst_n(rst_n), .clk_fx(fx_t), .start(start_v[2]),
        .busy(busy_t), .meas_valid(mv_t), .fx_cnt(fx_tc), .fs_cnt(fs_tc),
        .err_timeout(to_t), .err_ovf(ovf_t));
    equal_precision_freq_meter #(.GATE_CYCLES(9500), .TIMEOUT_CYCLES(20000), .AUTO_RESTART(1)) u_r (
        .sys_clk(sys_clk), .rst_n(rst_n), .clk_fx(clk_fx), .start(start_v[3]),
        .busy(busy_r), .meas_valid(mv_r), .fx_cnt(fx_r), .fs_cnt(fs_r),
        .err_timeout(to_r), .err_ovf(ovf_r));
    equal_precision_freq_meter #(.GATE_CYCLES(5000), .TIMEOUT_CYCLES(20000), .CNT_W(12)) u_o (
        .sys_clk(sys_clk), .rst_n(rst_n), .clk_fx(clk_fx), .start(start_v[4]),
        .busy(busy_o), .meas_valid(mv_o), .fx_cnt(fx_o), .fs_cnt(fs_o),
        .err_timeout(to_o), .err_ovf(ovf_o));

    // 50 MHz reference; clk_fx is reference / 1000, offset so its edges never race sys_clk.
    always #10 sys_clk = ~sys_clk;
    initial begin
        #10007;
        forever begin
            clk_fx = ~clk_fx;
            #10000;
        end
    end

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int mv_n_a = 0, mv_n_b = 0, mv_n_t = 0, mv_n_r = 0, mv_n_o = 0;
    int to_n_a = 0, to_n_t = 0, ovf_n_a = 0, ovf_n_o = 0;
    int to_cyc_t = 0, bad_r = 0, mv_cyc_r = 0, gap_r = 0;

    always @(negedge sys_clk) begin
        if (mv_a)  mv_n_a  <= mv_n_a + 1;
        if (mv_b)  mv_n_b  <= mv_n_b + 1;
        if (mv_t)  mv_n_t  <= mv_n_t + 1;
        if (mv_o)  mv_n_o  <= mv_n_o + 1;
        if (to_a)  to_n_a  <= to_n_a + 1;
        if (ovf_a) ovf_n_a <= ovf_n_a + 1;
        if (ovf_o) ovf_n_o <= ovf_n_o + 1;
        if (to_t) begin
            to_n_t   <= to_n_t + 1;
            to_cyc_t <= cyc;
        end
        if (mv_r) begin
            mv_n_r   <= mv_n_r + 1;
            mv_cyc_r <= cyc;
            if (mv_n_r > 0) gap_r <= cyc - mv_cyc_r;
            if (fx_r != 32'd10 || fs_r != 32'd10000) bad_r <= bad_r + 1;
        end
    end

    int n_pass = 0, n_fail = 0, n_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge sys_clk);
        #1;
    endtask

    task automatic pulse_start(input logic [4:0] sel, output int sampled_cyc);
        @(negedge sys_clk);
        start_v = sel;
        @(posedge sys_clk);
        #1;
        sampled_cyc = cyc;
        @(negedge sys_clk);
        start_v = '0;
        #1;
    endtask

    int st_cyc;

    initial begin
        wait_cycles(3);
        check("reset_busy", 64'(busy_a), 64'd0);
        check("reset_meas_valid", 64'(mv_a), 64'd0);
        check("reset_fx_cnt", 64'(fx_a), 64'd0);
        check("reset_fs_cnt", 64'(fs_a), 64'd0);
        check("reset_err_timeout", 64'(to_a), 64'd0);
        check("reset_err_ovf", 64'(ovf_a), 64'd0);

        @(negedge sys_clk);
        rst_n = 1'b1;
        wait_cycles(2);

        pulse_start(5'b11111, st_cyc);
        check("busy_after_start_a", 64'(busy_a), 64'd1);
        check("busy_after_start_o", 64'(busy_o), 64'd1);

        wait_cycles(6000);
        pulse_start(5'b01001, st_cyc);
        check("busy_mid_gate_r", 64'(busy_r), 64'd1);
        wait_cycles(8000);

        check("a_valid_count", 64'(mv_n_a), 64'd1);
        check("a_fx_cnt", 64'(fx_a), 64'd10);
        check("a_fs_cnt", 64'(fs_a), 64'd10000);
        check("a_err_timeout", 64'(to_n_a), 64'd0);
        check("a_err_ovf", 64'(ovf_n_a), 64'd0);
        check("a_busy_idle", 64'(busy_a), 64'd0);
        check("b_valid_count", 64'(mv_n_b), 64'd1);
        check("b_fx_cnt_edge_last", 64'(fx_b), 64'd11);
        check("b_fs_cnt_edge_last", 64'(fs_b), 64'd11000);
        check("t_fx_cnt", 64'(fx_tc), 64'd10);
        check("t_fs_cnt", 64'(fs_tc), 64'd10000);
        check("o_ovf_count", 64'(ovf_n_o), 64'd1);
        check("o_no_valid", 64'(mv_n_o), 64'd0);
        check("o_busy_idle", 64'(busy_o), 64'd0);
        check("o_fs_cnt_held", 64'(fs_o), 64'd0);

        fx_en_t = 1'b0;
        wait_cycles(10);
        pulse_start(5'b00100, st_cyc);
        wait_cycles(5100);
        check("t_timeout_count", 64'(to_n_t), 64'd1);
        check("t_timeout_latency", 64'(to_cyc_t - st_cyc), 64'd5000);
        check("t_busy_after_timeout", 64'(busy_t), 64'd0);
        check("t_fx_cnt_held", 64'(fx_tc), 64'd10);
        check("t_fs_cnt_held", 64'(fs_tc), 64'd10000);
        check("t_valid_count", 64'(mv_n_t), 64'd1);

        pulse_start(5'b00001, st_cyc);
        wait_cycles(3000);
        check("a_busy_in_gate", 64'(busy_a), 64'd1);
        a_rst_ok = 1'b0;
        #2;
        check("a_async_busy", 64'(busy_a), 64'd0);
        check("a_async_fx_cnt", 64'(fx_a), 64'd0);
        check("a_async_fs_cnt", 64'(fs_a), 64'd0);
        check("a_async_meas_valid", 64'(mv_a), 64'd0);
        wait_cycles(3);
        a_rst_ok = 1'b1;
        wait_cycles(2);
        pulse_start(5'b00001, st_cyc);
        wait_cycles(12500);
        check("a_valid_after_reset", 64'(mv_n_a), 64'd2);
        check("a_fx_after_reset", 64'(fx_a), 64'd10);
        check("a_fs_after_reset", 64'(fs_a), 64'd10000);

        check("r_repeats", 64'(mv_n_r >= 2), 64'd1);
        check("r_all_results_ok", 64'(bad_r), 64'd0);
        check("r_restart_period", 64'(gap_r), 64'd11000);
        check("r_fx_cnt", 64'(fx_r), 64'd10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
